// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase-adjust controller.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        LOCKWAIT,
        DONE
    } state_t;

    localparam logic [1:0] SEL_CLKOS  = 2'd0;
    localparam logic [1:0] SEL_CLKOS2 = 2'd1;
    localparam logic [1:0] SEL_CLKOS3 = 2'd2;
    localparam logic [1:0] SEL_CLKOP  = 2'd3;

    localparam logic OP_STEP   = 1'b0;
    localparam logic OP_RELOAD = 1'b1;

endpackage

// File: rtl/pll_phase_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Drives the EHXPLLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG port for step and
// reload commands, waits for LOCK to recover and tracks each output's fine phase.
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned LOCK_TMO  = 1000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [1:0]            req_sel,
    input  logic                  req_dir,
    input  logic [STEP_W-1:0]     req_steps,
    output logic                  done,
    output logic                  err,
    output logic [4*STEP_W-1:0]   phase_pos,
    input  logic                  pll_locked,
    output logic [1:0]            phasesel,
    output logic                  phasedir,
    output logic                  phasestep,
    output logic                  phaseloadreg
);

    localparam logic [STEP_W-1:0] POS_ONE = STEP_W'(1);

    state_t            state;
    logic [7:0]        cyc_cnt;
    logic [15:0]       tmo_cnt;
    logic [STEP_W-1:0] remaining;
    logic              op_q;
    logic              lock_s;
    logic [STEP_W-1:0] pos_q [4];

    sync2 u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lock_s)
    );

    assign req_ready = (state == IDLE);

    for (genvar g = 0; g < 4; g++) begin : g_pos
        assign phase_pos[g*STEP_W +: STEP_W] = pos_q[g];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            tmo_cnt      <= '0;
            remaining    <= '0;
            op_q         <= OP_STEP;
            phasesel     <= SEL_CLKOS;
            phasedir     <= 1'b0;
            phasestep    <= 1'b1;
            phaseloadreg <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            pos_q        <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        phasesel  <= req_sel;
                        phasedir  <= req_dir;
                        op_q      <= req_op;
                        remaining <= req_steps;
                        err       <= 1'b0;
                        cyc_cnt   <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (op_q == OP_STEP && remaining == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cyc_cnt == 8'(SETUP_CYC)) begin
                        cyc_cnt <= '0;
                        state   <= PULSE;
                        if (op_q == OP_RELOAD) phaseloadreg <= 1'b0;
                        else                   phasestep    <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                PULSE: begin
                    if (cyc_cnt == 8'(PULSE_CYC - 1)) begin
                        phasestep    <= 1'b1;
                        phaseloadreg <= 1'b1;
                        cyc_cnt      <= '0;
                        state        <= GAP;
                        // Counter tracks the PLL: it moves when the strobe rises.
                        if (op_q == OP_RELOAD) begin
                            pos_q[phasesel] <= '0;
                        end else begin
                            remaining <= remaining - POS_ONE;
                            if (phasedir) pos_q[phasesel] <= pos_q[phasesel] - POS_ONE;
                            else          pos_q[phasesel] <= pos_q[phasesel] + POS_ONE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cyc_cnt == 8'(GAP_CYC - 1)) begin
                        cyc_cnt <= '0;
                        if (op_q == OP_STEP && remaining != '0) begin
                            phasestep <= 1'b0;
                            state     <= PULSE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= LOCKWAIT;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                LOCKWAIT: begin
                    // Lock is tested first so a simultaneous timeout still reports success.
                    if (lock_s) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (tmo_cnt == 16'(LOCK_TMO)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
